// File: rtl/eth_fifo_pkg.sv
// Shared definitions for the frame arbiter: FSM encoding, beat counter width
// and the position of the end-of-frame marker inside a FIFO word.
package eth_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Wide enough for a 1518-beat frame.
  localparam int CNT_W = 11;

  // The marker sits directly above the payload, i.e. at the MSB of fifo_din.
  function automatic int eof_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after `last`, with wrap.
// Purely combinational; `any` is low when nothing is requesting.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  // Walk the requesters starting one past the previous owner; first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(last) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = $clog2(N)'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_frame_arbiter.sv
// Frame-level arbiter feeding one shared sync FIFO. A requester owns the FIFO
// for an entire frame; frames longer than MAX_BEATS are cut with a forced
// end marker and the remainder is swallowed without writing.
module fifo_frame_arbiter
  import eth_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 1518
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH:0]           fifo_din,
  output logic                          fifo_wen,
  input  logic                          fifo_afull,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          ovf_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_any;
  logic [NUM_REQ-1:0]  own_oh;
  logic [CNT_W-1:0]    beat_cnt;
  logic                cur_valid;
  logic                cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                at_max;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign cur_valid = |(req_valid & own_oh);
  assign cur_last  = |(req_last & own_oh);
  assign cur_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  // beat_cnt holds beats already accepted, so this is "current beat is MAX_BEATS".
  assign at_max    = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Handshake and FIFO write decode; everything is forced low while in reset.
  always_comb begin
    req_ready  = '0;
    fifo_wen   = 1'b0;
    fifo_din   = '0;
    frame_done = 1'b0;
    ovf_err    = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_XFER: begin
          // afull leaves four entries of slack, so full is never consulted.
          req_ready                       = fifo_afull ? '0 : own_oh;
          fifo_wen                        = cur_valid & ~fifo_afull;
          fifo_din[DATA_WIDTH-1:0]        = cur_data;
          fifo_din[eof_bit(DATA_WIDTH)]   = cur_last | at_max;
          frame_done                      = fifo_wen & (cur_last | at_max);
          ovf_err                         = fifo_wen & at_max & ~cur_last;
        end
        ST_DRAIN: req_ready = own_oh;
        default: ;
      endcase
    end
  end

  // Ownership FSM: arbitrate in IDLE, stream in XFER, swallow overlong tail in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      own_oh     <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_any) begin
          grant_id <= pick_idx;
          own_oh   <= pick_oh;
          beat_cnt <= '0;
          state    <= ST_XFER;
        end
        ST_XFER: if (fifo_wen) begin
          if (cur_last) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end else if (at_max) begin
            state <= ST_DRAIN;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DRAIN: if (cur_valid && cur_last) begin
          last_grant <= grant_id;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_arbiter.sv
// Bench for fifo_frame_arbiter: per-requester frame sources, a transaction
// model of frame ownership checked every cycle, and directed scenarios with
// hand-derived totals and timings.
module tb_fifo_frame_arbiter;

  localparam int NR = 4, DW = 8, MAXB = 1518, IW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0, req_last = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [DW:0]       fifo_din;
  logic              fifo_wen;
  logic              fifo_afull = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy, frame_done, ovf_err;

  always #5 clk = ~clk;

  fifo_frame_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
    .fifo_wen(fifo_wen), .fifo_afull(fifo_afull), .grant_id(grant_id),
    .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err)
  );

  int n_checks = 0, n_fail = 0;

  // sources
  int src_frames[NR], src_len[NR], src_cur_len[NR], src_pos[NR];
  logic [DW-1:0] src_data[NR];
  int vmode = 0, afull_mode = 0, af_lo = 0, af_hi = 0, cyc = 0;

  // model: who owns the FIFO (-1 = nobody), beats written, tail being swallowed
  int m_owner = -1, m_cnt = 0, m_lastg = NR - 1, m_gid = 0;
  bit m_drain = 0;

  // observed statistics
  int st_wr, st_ovf, st_done, st_mark_idx, st_drained, st_af_wr, st_stall, st_gid_bad;
  int wr_cyc[$], m_glog[$], d_glog[$];
  logic prev_busy = 1'b0;
  logic [IW-1:0] held_gid = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic new_frame(input int i);
    src_cur_len[i] = (src_len[i] > 0) ? src_len[i] : int'($urandom_range(1, 20));
    src_pos[i]     = 0;
  endtask

  task automatic start(input int i, input int frames, input int len);
    src_frames[i] = frames;
    src_len[i]    = len;
    new_frame(i);
    src_data[i]   = DW'($urandom);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_frames[i] = 0; src_len[i] = 0; src_cur_len[i] = 1; src_pos[i] = 0; src_data[i] = '0;
    end
  endtask

  task automatic clear_stats();
    st_wr = 0; st_ovf = 0; st_done = 0; st_mark_idx = 0; st_drained = 0;
    st_af_wr = 0; st_stall = 0; st_gid_bad = 0; cyc = 0;
    wr_cyc.delete(); m_glog.delete(); d_glog.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bit g;
      case (vmode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 99) < 70);
        default: g = (cyc % 2 == 0);
      endcase
      req_valid[i]         = (src_frames[i] > 0) && g;
      req_last[i]          = (src_frames[i] > 0) && (src_pos[i] == src_cur_len[i] - 1);
      req_data[i*DW +: DW] = src_data[i];
    end
    case (afull_mode)
      0:       fifo_afull = 1'b0;
      1:       fifo_afull = ($urandom_range(0, 99) < 25);
      default: fifo_afull = (cyc >= af_lo) && (cyc < af_hi);
    endcase
  endtask

  // One clock: drive, compare against the model at negedge, advance model and sources.
  task automatic step();
    logic [NR-1:0] er;
    logic ew, ed, eo, eb, lst, hm, acc;
    logic [DW:0] edin;
    int o;
    drive();
    @(negedge clk);
    er = '0; ew = 0; ed = 0; eo = 0; eb = 0; edin = '0;
    if (rst) begin
      m_owner = -1; m_drain = 0; m_cnt = 0; m_lastg = NR - 1; m_gid = 0;
    end else if (m_owner < 0) begin
      chk("grant_id_idle", 32'(grant_id), 32'(m_gid));
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_lastg + k) % NR;
        if (m_owner < 0 && req_valid[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_gid = m_owner; m_cnt = 0; m_drain = 0; m_glog.push_back(m_owner);
      end
    end else begin
      o = m_owner; lst = req_last[o]; eb = 1;
      chk("grant_id_own", 32'(grant_id), 32'(o));
      if (!m_drain) begin
        hm    = (m_cnt + 1 == MAXB);
        er[o] = !fifo_afull;
        acc   = req_valid[o] && !fifo_afull;
        ew    = acc;
        edin  = {lst | hm, req_data[o*DW +: DW]};
        ed    = acc && (lst || hm);
        eo    = acc && hm && !lst;
        if (acc) begin
          m_cnt++;
          if (lst) begin m_owner = -1; m_lastg = o; end
          else if (hm) m_drain = 1;
        end
      end else begin
        er[o] = 1'b1;
        if (req_valid[o] && lst) begin m_owner = -1; m_lastg = o; end
      end
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("fifo_wen", 32'(fifo_wen), 32'(ew));
    chk("busy", 32'(busy), 32'(eb));
    chk("frame_done", 32'(frame_done), 32'(ed));
    chk("ovf_err", 32'(ovf_err), 32'(eo));
    if (ew || rst) chk("fifo_din", 32'(fifo_din), 32'(edin));

    // observed statistics from the DUT pins
    if (fifo_wen) begin
      st_wr++;
      wr_cyc.push_back(cyc);
      if (fifo_din[DW] && st_mark_idx == 0) st_mark_idx = st_wr;
      if (fifo_afull) st_af_wr++;
    end
    st_ovf  += int'(ovf_err);
    st_done += int'(frame_done);
    if (busy && !fifo_wen && ((req_ready & req_valid) != '0)) st_drained++;
    if (busy && fifo_afull && !fifo_wen && req_ready == '0) st_stall++;
    if (busy && !prev_busy) begin d_glog.push_back(int'(grant_id)); held_gid = grant_id; end
    else if (busy && grant_id != held_gid) st_gid_bad++;
    prev_busy = busy;

    // sources consume beats the model says were accepted
    for (int i = 0; i < NR; i++) begin
      if (er[i] && req_valid[i]) begin
        if (req_last[i]) begin
          src_frames[i]--;
          if (src_frames[i] > 0) new_frame(i);
        end else begin
          src_pos[i]++;
        end
        src_data[i] = DW'($urandom);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (src_frames[i] > 0) return 1'b0;
    return (m_owner < 0);
  endfunction

  task automatic run(input int bound, input string nm);
    int n;
    n = 0;
    while (n < bound && !all_done()) begin step(); n++; end
    if (n >= bound) begin
      n_checks++; n_fail++;
      $display("FAIL timeout %s: still busy after %0d cycles, expected completion", nm, bound);
    end
    step(); step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    vmode = 0; afull_mode = 0;
    step(); step();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    int n;
    clear_sources();
    clear_stats();

    // reset state
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    // req 0 and 2 with 3-beat frames at reset release
    start(0, 1, 3); start(2, 1, 3);
    run(100, "two_req");
    chk("two_req_writes", 32'(st_wr), 32'd6);
    chk("two_req_done", 32'(st_done), 32'd2);
    chk("two_req_grants", 32'(d_glog.size()), 32'd2);
    if (d_glog.size() == 2) begin
      chk("two_req_first", 32'(d_glog[0]), 32'd0);
      chk("two_req_second", 32'(d_glog[1]), 32'd2);
    end
    chk("two_req_wr_count", 32'(wr_cyc.size()), 32'd6);
    if (wr_cyc.size() == 6) begin
      int exp_c[6] = '{1, 2, 3, 5, 6, 7};
      for (int k = 0; k < 6; k++) chk("two_req_wr_cycle", 32'(wr_cyc[k]), 32'(exp_c[k]));
    end

    // all four with single-beat frames: strict rotation, every word marked
    do_reset();
    for (int i = 0; i < NR; i++) start(i, 2, 1);
    run(100, "rotate");
    chk("rotate_writes", 32'(st_wr), 32'd8);
    chk("rotate_marked", 32'(st_mark_idx), 32'd1);
    chk("rotate_grants", 32'(d_glog.size()), 32'd8);
    if (d_glog.size() == 8 && m_glog.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk("rotate_grant_dut", 32'(d_glog[k]), 32'(k % 4));
        chk("rotate_grant_model", 32'(m_glog[k]), 32'(k % 4));
      end

    // afull held five cycles mid-frame
    do_reset();
    afull_mode = 2; af_lo = 4; af_hi = 9;
    start(1, 1, 10);
    run(100, "afull");
    chk("afull_writes", 32'(st_wr), 32'd10);
    chk("afull_stall_cycles", 32'(st_stall), 32'd5);
    chk("afull_write_while_afull", 32'(st_af_wr), 32'd0);

    // 1600-beat frame truncated at MAX_BEATS
    do_reset();
    start(1, 1, 1600);
    run(2000, "overflow");
    chk("ovf_writes", 32'(st_wr), 32'd1518);
    chk("ovf_marker_at", 32'(st_mark_idx), 32'd1518);
    chk("ovf_pulses", 32'(st_ovf), 32'd1);
    chk("ovf_done_pulses", 32'(st_done), 32'd1);
    chk("ovf_drained", 32'(st_drained), 32'd82);

    // reset during beat 5 of a 10-beat frame
    do_reset();
    start(2, 1, 10);
    n = 0;
    while (!(m_owner == 2 && src_pos[2] == 4) && n < 50) begin step(); n++; end
    chk("midrst_reached_beat5", 32'(src_pos[2]), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_sources();
    clear_stats();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_wen", 32'(fifo_wen), 32'd0);
    start(3, 1, 2); start(0, 1, 2);
    run(100, "midrst");
    chk("midrst_grants", 32'(d_glog.size()), 32'd2);
    if (d_glog.size() == 2) chk("midrst_first_grant", 32'(d_glog[0]), 32'd0);

    // valid toggling every cycle
    do_reset();
    vmode = 2;
    start(3, 1, 7);
    run(100, "toggle");
    chk("toggle_writes", 32'(st_wr), 32'd7);
    chk("toggle_gid_changes", 32'(st_gid_bad), 32'd0);
    chk("toggle_done", 32'(st_done), 32'd1);

    // randomized traffic with random afull
    do_reset();
    for (int i = 0; i < NR; i++) start(i, 3, 0);
    vmode = 1; afull_mode = 1;
    run(3000, "random");
    chk("random_done", 32'(st_done), 32'd12);
    chk("random_write_while_afull", 32'(st_af_wr), 32'd0);
    chk("random_ovf", 32'(st_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_frame_arbiter.md
FIFO_FRAME_ARBITER -- requirements
Module: fifo_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of frame requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, beat payload width.
REQ-003 SHALL have parameter MAX_BEATS, default 1518, longest legal frame in beats.
REQ-004 SHALL have port clk  in  1  clock; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last  in  NUM_REQ  marks the final beat of a frame.
REQ-009 SHALL have port req_ready  out  NUM_REQ  beat accepted when valid and ready are both high.
REQ-010 SHALL have port fifo_din  out  DATA_WIDTH+1  MSB = end-of-frame marker, LSBs = payload.
REQ-011 SHALL have port fifo_wen  out  1  write strobe to the shared sync FIFO.
REQ-012 SHALL have port fifo_afull  in  1  FIFO almost-full (depth-4 threshold), registered.
REQ-013 SHALL have port grant_id  out  $clog2(NUM_REQ)  index of the current owner.
REQ-014 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse when a frame's last beat is written.
REQ-016 SHALL have port ovf_err  out  1  one-cycle pulse on a frame truncated at MAX_BEATS.

Function
REQ-017 SHALL implement FSM states IDLE, XFER, DRAIN.
REQ-018 IDLE: when any req_valid is high, SHALL select the first requester with valid high, searching round-robin from last_grant+1 with wrap; SHALL latch grant_id and enter XFER on the next cycle, giving one cycle of arbitration latency.
REQ-019 XFER: req_ready[grant_id] = ~fifo_afull, all other ready bits 0; fifo_wen = req_valid[grant_id] & ~fifo_afull; fifo_din = {req_last[grant_id], req_data slice}, all combinational.
REQ-020 SHALL never assert fifo_wen while fifo_afull is high; fifo_full is deliberately not used, because afull leaves 4 entries of margin for flag latency.
REQ-021 SHALL count accepted beats in an 11-bit counter (sized for MAX_BEATS); the counter clears on entry to XFER.
REQ-022 On an accepted beat with req_last high: frame_done pulses in the same cycle, last_grant <= grant_id, next state IDLE.
REQ-023 On the accepted beat numbered MAX_BEATS with req_last low: the written beat SHALL carry the marker forced to 1, ovf_err pulses, frame_done pulses, and the FSM enters DRAIN.
REQ-024 DRAIN: req_ready[grant_id] = 1, fifo_wen = 0; accepted beats are discarded; on an accepted beat with last high, last_grant <= grant_id and the FSM enters IDLE.
REQ-025 Ownership is held for the whole frame; other requesters SHALL never receive ready mid-frame.
REQ-026 A frame with one beat (valid and last on the first beat) SHALL complete in a single XFER cycle.
REQ-027 Requester valid dropping mid-frame SHALL stall the transfer without losing ownership.
REQ-028 Back-to-back frames SHALL be separated by exactly one IDLE cycle.

Reset
REQ-029 On rst: state IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority), beat counter 0, grant_id 0.
REQ-030 During rst: all outputs SHALL be 0 (req_ready, fifo_wen, fifo_din, busy, frame_done, ovf_err); mid-frame reset SHALL abandon the frame without a forced marker, and the FIFO is reset together with this block.

Structure
REQ-031 State encoding and the fifo_din marker-bit position SHALL be defined in the shared package eth_fifo_pkg.
REQ-032 Round-robin selection SHALL be one sub-module, rr_pick, combinational: request vector plus last pointer in, one-hot grant plus index out.

Verification
REQ-033 Requesters 0 and 2 both valid at reset release with 3-beat frames -> req 0 granted first, 3 writes, then 1 idle cycle, then req 2; frame_done pulses twice.
REQ-034 All 4 requesters continuously valid with 1-beat frames -> grants follow 0,1,2,3,0; each write carries marker = 1.
REQ-035 fifo_afull asserted for 5 cycles mid-frame -> fifo_wen low and req_ready low for those 5 cycles; no beat is lost or duplicated.
REQ-036 Requester 1 sends 1600 beats with last only on beat 1600 -> 1518 writes, marker set on write 1518, ovf_err pulses once, and 82 beats are drained with no write.
REQ-037 rst pulsed during beat 5 of a 10-beat frame -> next cycle outputs are 0, state IDLE, and requester 0 has priority afterwards.
REQ-038 Requester valid toggling every cycle during a frame -> grant_id stays constant and write count equals frame length.
